buf_addr_alloc: RTL and testbench

BUF_ADDR_ALLOC -- requirements
Module: buf_addr_alloc

---
 rtl/buf_addr_alloc.sv | 51 +++++
 tb/tb_buf_addr_alloc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_addr_alloc.sv
// buf_addr_alloc: circular free-list address allocator with an in-use bitmap guarding returns
module buf_addr_alloc #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_ready,
  output logic                  alloc_valid,
  output logic [ADDR_WIDTH-1:0] alloc_addr,
  input  logic                  free_en,
  input  logic [ADDR_WIDTH-1:0] free_addr,
  output logic                  free_err,
  output logic                  alloc_err,
  output logic [ADDR_WIDTH:0]   free_count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] list [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DEPTH-1:0]      in_use, in_use_nxt;
  logic                  do_alloc, do_free;
  assign alloc_valid = cnt != '0;
  assign alloc_addr  = list[rd_ptr];
  assign free_count  = cnt;
  assign alloc_err   = alloc_ready & ~alloc_valid;
  assign do_alloc    = alloc_valid & alloc_ready;
  // The bitmap is the only overflow guard: a free address can never be returned twice.
  assign do_free     = free_en & in_use[free_addr];
  always_comb begin
    in_use_nxt = in_use;
    if (do_alloc) in_use_nxt[alloc_addr] = 1'b1;
    if (do_free) in_use_nxt[free_addr] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) list[i] <= ADDR_WIDTH'(i);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= (ADDR_WIDTH+1)'(DEPTH);
      in_use   <= '0;
      free_err <= 1'b0;
    end else begin
      if (do_free) list[wr_ptr] <= free_addr;
      rd_ptr   <= rd_ptr + ADDR_WIDTH'(do_alloc);
      wr_ptr   <= wr_ptr + ADDR_WIDTH'(do_free);
      cnt      <= cnt + (ADDR_WIDTH+1)'(do_free) - (ADDR_WIDTH+1)'(do_alloc);
      in_use   <= in_use_nxt;
      free_err <= free_en & ~in_use[free_addr];
    end
  end
endmodule

// File: tb/tb_buf_addr_alloc.sv
// tb_buf_addr_alloc: scenario tasks plus a free-list model whose queue scoreboards every allocation
module tb_buf_addr_alloc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_ready = 1'b0;
  logic       alloc_valid;
  logic [2:0] alloc_addr;
  logic       free_en = 1'b0;
  logic [2:0] free_addr = '0;
  logic       free_err;
  logic       alloc_err;
  logic [3:0] free_count;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_q[$];
  bit         used[8];
  bit         exp_ferr;

  buf_addr_alloc #(.ADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_ready(alloc_ready), .alloc_valid(alloc_valid),
    .alloc_addr(alloc_addr), .free_en(free_en), .free_addr(free_addr), .free_err(free_err),
    .alloc_err(alloc_err), .free_count(free_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(i);
      used[i] = 1'b0;
    end
    exp_ferr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    alloc_ready = 1'b0;
    free_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle of stimulus; the scoreboard pops the expected head on every modelled allocation.
  task automatic step(input bit ar, input bit fe, input logic [2:0] fa);
    bit a, f;
    int x;
    @(negedge clk);
    alloc_ready = ar;
    free_en = fe;
    free_addr = fa;
    #1;
    a = ar && exp_q.size() != 0;
    n_cmp++;
    if (alloc_valid !== (exp_q.size() != 0)) begin
      n_bad++;
      $display("FAIL alloc_valid: got %0b expected %0b", alloc_valid, exp_q.size() != 0);
    end
    if (a) begin
      x = exp_q.pop_front();
      n_cmp++;
      if (alloc_addr !== 3'(x)) begin
        n_bad++;
        $display("FAIL alloc_addr: got %0d expected %0d", alloc_addr, x);
      end
    end
    f = fe && used[fa];
    exp_ferr = fe && !used[fa];
    if (a) used[x] = 1'b1;
    if (f) begin
      used[fa] = 1'b0;
      exp_q.push_back(int'(fa));
    end
    @(posedge clk);
    #1;
    alloc_ready = 1'b0;
    free_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_cmp++;
    if (alloc_valid !== 1'b1 || alloc_addr !== 3'd0 || free_count !== 4'd8 || alloc_err !== 1'b0 || free_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: got v=%0b a=%0d c=%0d ae=%0b fe=%0b expected 1 0 8 0 0",
               alloc_valid, alloc_addr, free_count, alloc_err, free_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      n_cmp++;
      if (free_count !== 4'(7 - i)) begin
        n_bad++;
        $display("FAIL drain_count: got %0d expected %0d", free_count, 7 - i);
      end
    end
    n_cmp++;
    if (alloc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_empty: got %0b expected 0", alloc_valid);
    end
    @(negedge clk);
    alloc_ready = 1'b1;
    #1;
    n_cmp++;
    if (alloc_err !== 1'b1 || free_count !== 4'd0) begin
      n_bad++;
      $display("FAIL alloc_err_empty: got ae=%0b c=%0d expected 1 0", alloc_err, free_count);
    end
    @(posedge clk);
    #1;
    alloc_ready = 1'b0;
    n_cmp++;
    if (free_count !== 4'd0 || alloc_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_no_change: got c=%0d v=%0b expected 0 0", free_count, alloc_valid);
    end
  endtask

  task automatic test_return();
    step(0, 1, 5);
    n_cmp++;
    if (free_count !== 4'd1 || alloc_valid !== 1'b1 || free_err !== 1'b0) begin
      n_bad++;
      $display("FAIL return5: got c=%0d v=%0b fe=%0b expected 1 1 0", free_count, alloc_valid, free_err);
    end
    step(0, 1, 2);
    n_cmp++;
    if (free_count !== 4'd2) begin
      n_bad++;
      $display("FAIL return2: got %0d expected 2", free_count);
    end
    step(1, 0, 0);
    step(1, 0, 0);
    n_cmp++;
    if (free_count !== 4'd0) begin
      n_bad++;
      $display("FAIL return_realloc: got %0d expected 0", free_count);
    end
  endtask

  task automatic test_double_free();
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    n_cmp++;
    if (free_err !== 1'b0 || free_count !== 4'd8) begin
      n_bad++;
      $display("FAIL first_free: got fe=%0b c=%0d expected 0 8", free_err, free_count);
    end
    step(0, 1, 0);
    n_cmp++;
    if (free_err !== 1'b1 || free_count !== 4'd8) begin
      n_bad++;
      $display("FAIL double_free: got fe=%0b c=%0d expected 1 8", free_err, free_count);
    end
    step(0, 0, 0);
    n_cmp++;
    if (free_err !== 1'b0) begin
      n_bad++;
      $display("FAIL free_err_pulse: got %0b expected 0", free_err);
    end
    step(0, 1, 7);
    n_cmp++;
    if (free_err !== 1'b1 || free_count !== 4'd8) begin
      n_bad++;
      $display("FAIL never_alloc: got fe=%0b c=%0d expected 1 8", free_err, free_count);
    end
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 1, 1);
    n_cmp++;
    if (free_count !== 4'd5 || free_err !== 1'b0) begin
      n_bad++;
      $display("FAIL simul: got c=%0d fe=%0b expected 5 0", free_count, free_err);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(0, 1, 3);
    n_cmp++;
    if (free_err !== 1'b0 || free_count !== 4'd1) begin
      n_bad++;
      $display("FAIL simul_3_in_use: got fe=%0b c=%0d expected 0 1", free_err, free_count);
    end
  endtask

  task automatic test_simul_same();
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(1, 1, 4);
    n_cmp++;
    if (free_err !== 1'b1 || free_count !== 4'd3) begin
      n_bad++;
      $display("FAIL simul_same: got fe=%0b c=%0d expected 1 3", free_err, free_count);
    end
    step(0, 1, 4);
    n_cmp++;
    if (free_err !== 1'b0 || free_count !== 4'd4) begin
      n_bad++;
      $display("FAIL simul_same_in_use: got fe=%0b c=%0d expected 0 4", free_err, free_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (free_count !== 4'd8 || alloc_addr !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got c=%0d a=%0d expected 8 0", free_count, alloc_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 2);
    n_cmp++;
    if (free_err !== 1'b1 || free_count !== 4'd8) begin
      n_bad++;
      $display("FAIL reset_mid_free: got fe=%0b c=%0d expected 1 8", free_err, free_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      n_cmp++;
      if (free_err !== exp_ferr || free_count !== 4'(exp_q.size())) begin
        n_bad++;
        $display("FAIL random: got fe=%0b c=%0d expected %0b %0d", free_err, free_count, exp_ferr, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_return();
    test_double_free();
    test_simul();
    test_simul_same();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
